// File: rtl/uart_pkg.sv
// Shared UART types: frame configuration encodings, transmitter FSM states and
// a parity helper used by the serialiser.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {DBIT5 = 2'd0, DBIT6 = 2'd1, DBIT7 = 2'd2, DBIT8 = 2'd3} uart_data_lenght_t;
  typedef enum logic {STOP1 = 1'b0, STOP2 = 1'b1} uart_stop_bits_t;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} uart_parity_mode_t;

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} uart_tx_state_t;

  function automatic logic [7:0] data_mask(input uart_data_lenght_t len);
    case (len)
      DBIT5:   return 8'h1F;
      DBIT6:   return 8'h3F;
      DBIT7:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // High bits beyond the configured length never reach the line, so they are
  // excluded from the parity as well.
  function automatic logic parity_bit(input logic [7:0] data, input uart_data_lenght_t len,
                                      input uart_parity_mode_t mode);
    return (^(data & data_mask(len))) ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Link between the transmitter and the register block's TX buffer.
// Pop handshake: tx_fetch_o is a 1-cycle strobe that pops one byte at the
// rising edge it is sampled on; it is only raised while tx_empty_i=0, and the
// popped byte is on tx_data_i during the following cycle.
interface uart_transmitter_if;
  logic [7:0] tx_data_i;
  logic       tx_empty_i;
  logic       tx_fetch_o;

  modport master (output tx_fetch_o, input tx_data_i, input tx_empty_i);
  modport slave  (input tx_fetch_o, output tx_data_i, output tx_empty_i);
endinterface

// File: rtl/baud_rate_generator.sv
// Oversampling tick source: one tick every divider_i+1 clocks while not cleared.
// Shared between the UART transmitter and receiver.
module baud_rate_generator (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [14:0] divider_i,
  output logic        tick_o
);

  logic [14:0] r_cnt;

  // >= rather than == so a divider lowered mid-count still produces a tick.
  assign tick_o = !clear_i && (r_cnt >= divider_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || tick_o) r_cnt <= '0;
    else                            r_cnt <= r_cnt + 15'd1;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART serialiser: pops bytes from the TX buffer and frames them as start,
// 5-8 data bits LSB-first, optional parity and 1/2 stop bits on tx_o.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_enable_i,
  input  logic                 flow_control_i,
  input  logic                 cts_n_i,
  input  uart_data_lenght_t    data_lenght_i,
  input  uart_stop_bits_t      stop_bits_i,
  input  uart_parity_mode_t    parity_mode_i,
  input  logic                 parity_enable_i,
  input  logic [14:0]          divider_i,
  uart_transmitter_if.master   bus,
  output logic                 tx_o,
  output logic                 tx_done_o,
  output logic                 busy_o,
  output uart_tx_state_t       state_o
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  uart_tx_state_t    r_state, w_state_next;
  logic              r_cts_meta, r_cts_sync;
  logic              w_ok_to_send, w_start, w_fetch;
  logic              w_tick, w_baud_clear, w_bit_done;
  logic [TICK_W-1:0] r_tick_num;
  logic [2:0]        r_bit_cnt, w_bit_cnt_next;
  logic [7:0]        r_shift, w_shift_next;
  uart_data_lenght_t r_len;
  uart_stop_bits_t   r_stop;
  logic              r_par_en, r_par;
  logic              r_tx, w_tx_next;
  logic              r_done, w_done_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n_i;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_ok_to_send = !flow_control_i || !r_cts_sync;
  assign w_start      = tx_enable_i && !bus.tx_empty_i && w_ok_to_send;

  // Divider is held cleared until the start bit so every frame is phase-aligned.
  assign w_baud_clear = (r_state == IDLE) || (r_state == FETCH);

  baud_rate_generator u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_baud_clear),
    .divider_i (divider_i),
    .tick_o    (w_tick)
  );

  assign w_bit_done = w_tick && (r_tick_num == LAST_TICK);

  always_comb begin
    w_state_next   = r_state;
    w_fetch        = 1'b0;
    w_done_next    = 1'b0;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_fetch      = 1'b1;
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        w_shift_next = bus.tx_data_i;
        w_state_next = START;
      end
      START: begin
        if (w_bit_done) begin
          w_bit_cnt_next = '0;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == (3'd4 + {1'b0, r_len})) begin
            w_bit_cnt_next = '0;
            w_state_next   = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_bit_cnt_next = '0;
          w_state_next   = STOP;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          if ((r_stop == STOP2) && (r_bit_cnt == 3'd0)) begin
            w_bit_cnt_next = 3'd1;
          end else begin
            w_done_next = 1'b1;
            if (w_start) begin
              w_fetch      = 1'b1;
              w_state_next = FETCH;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // tx_o is registered, so its next level follows the next state.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = r_par;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_tick_num <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
      if (w_baud_clear || w_bit_done) r_tick_num <= '0;
      else if (w_tick)                r_tick_num <= r_tick_num + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len    <= DBIT8;
      r_stop   <= STOP1;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
    end else if (r_state == FETCH) begin
      r_len    <= data_lenght_i;
      r_stop   <= stop_bits_i;
      r_par_en <= parity_enable_i;
      r_par    <= parity_bit(bus.tx_data_i, data_lenght_i, parity_mode_i);
    end
  end

  assign bus.tx_fetch_o = w_fetch;
  assign tx_o           = r_tx;
  assign tx_done_o      = r_done;
  assign busy_o         = (r_state != IDLE);
  assign state_o        = r_state;

endmodule
